// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: hazard/stall controller beside the ID stage of the 5-stage MIPS core.
// Covers load-use interlock with configurable load distance, a mult/div HI/LO interlock
// driven by a busy counter, interrupt latching across stalls, and PC/IF/ID hold/flush steering.
// Optional feature macro: HAZARD_PERF_EN adds saturating stall/flush performance counters.
module hazard_unit_mc #(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned PCSRC_W  = 3,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned MDU_LAT  = 32,
  parameter int unsigned CNT_W    = 6,
  parameter int unsigned PERF_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic               id_uses_rs,
  input  logic               id_uses_rt,
  input  logic               id_reads_hilo,
  input  logic               id_is_mdu,
  input  logic [PCSRC_W-1:0] id_pcsrc,
  input  logic               ex_memrd,
  input  logic [REG_W-1:0]   ex_rt,
  input  logic               mem_memrd,
  input  logic [REG_W-1:0]   mem_rt,
  input  logic [PCSRC_W-1:0] ex_pcsrc,
  input  logic               ex_alu_zero,
  input  logic               mdu_start,
  input  logic               undefine,
  input  logic               irq_valid,
  output logic               pc_hold,
  output logic               if_hold,
  output logic               if_flush,
  output logic               id_flush,
  output logic               mdu_busy,
`ifdef HAZARD_PERF_EN
  output logic [PERF_W-1:0]  perf_stall_cnt,
  output logic [PERF_W-1:0]  perf_flush_cnt,
`endif
  output logic               irq_ack
);

  localparam logic [PCSRC_W-1:0] PCSRC_BRANCH = PCSRC_W'(1);
  localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = PCSRC_W'(2);
  localparam logic [PCSRC_W-1:0] PCSRC_JR     = PCSRC_W'(3);
  localparam logic [CNT_W-1:0]   CNT_LOAD     = CNT_W'(MDU_LAT);
  localparam logic               MDU_EN       = (MDU_LAT != 0);
  localparam logic               MEM_CHECK_EN = (LOAD_LAT == 2);

  logic [CNT_W-1:0] r_cnt;
  logic             r_irq_pending;

  logic w_dep_ex;
  logic w_dep_mem;
  logic w_load_stall;
  logic w_mdu_busy;
  logic w_mdu_stall;
  logic w_stall;
  logic w_redirect_ex;
  logic w_id_jump;
  logic w_irq_req;

  // Register dependencies of the ID instruction on in-flight loads ($zero never creates one).
  always_comb begin
    w_dep_ex  = ex_memrd &&
                ((id_uses_rs && (id_rs != '0) && (id_rs == ex_rt)) ||
                 (id_uses_rt && (id_rt != '0) && (id_rt == ex_rt)));
    w_dep_mem = MEM_CHECK_EN && mem_memrd &&
                ((id_uses_rs && (id_rs != '0) && (id_rs == mem_rt)) ||
                 (id_uses_rt && (id_rt != '0) && (id_rt == mem_rt)));
  end

  // Stall, redirect and interrupt request terms feeding the priority steering.
  always_comb begin
    w_load_stall  = w_dep_ex || w_dep_mem;
    w_mdu_busy    = (r_cnt != '0);
    w_mdu_stall   = w_mdu_busy && (id_reads_hilo || id_is_mdu);
    w_stall       = w_load_stall || w_mdu_stall;
    w_redirect_ex = ((ex_pcsrc == PCSRC_BRANCH) && ex_alu_zero) || undefine;
    w_id_jump     = (id_pcsrc == PCSRC_JUMP) || (id_pcsrc == PCSRC_JR);
    w_irq_req     = r_irq_pending || irq_valid;
  end

  // Priority steering: stall > EX redirect/exception > ID jump or irq service > idle; reset forces all low.
  always_comb begin
    pc_hold  = 1'b0;
    if_hold  = 1'b0;
    if_flush = 1'b0;
    id_flush = 1'b0;
    irq_ack  = 1'b0;
    mdu_busy = 1'b0;
    if (!reset) begin
      mdu_busy = w_mdu_busy;
      if (w_stall) begin
        pc_hold  = 1'b1;
        if_hold  = 1'b1;
        id_flush = 1'b1;
      end else if (w_redirect_ex) begin
        if_flush = 1'b1;
        id_flush = 1'b1;
      end else if (w_id_jump || w_irq_req) begin
        if_flush = 1'b1;
        irq_ack  = w_irq_req;
      end
    end
  end

  // Mult/div busy counter: (re)loads on start, counts down to zero and holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (mdu_start && MDU_EN) begin
      r_cnt <= CNT_LOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Interrupt latch: holds a request until a cycle that can service it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_pending <= 1'b0;
    end else if (irq_ack) begin
      r_irq_pending <= irq_valid;
    end else begin
      r_irq_pending <= r_irq_pending || irq_valid;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] r_perf_stall;
  logic [PERF_W-1:0] r_perf_flush;

  // Saturating counts of PC-hold cycles and IF-flush cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (pc_hold && (r_perf_stall != '1)) begin
        r_perf_stall <= r_perf_stall + PERF_W'(1);
      end
      if (if_flush && (r_perf_flush != '1)) begin
        r_perf_flush <= r_perf_flush + PERF_W'(1);
      end
    end
  end

  assign perf_stall_cnt = r_perf_stall;
  assign perf_flush_cnt = r_perf_flush;
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: two instances (LOAD_LAT=1/MDU_LAT=32 and LOAD_LAT=2/MDU_LAT=4)
// share stimulus; a timestamp-based reference model predicts every output each cycle.
module tb_hazard_unit_mc;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt, mem_rt;
  logic       id_uses_rs, id_uses_rt, id_reads_hilo, id_is_mdu;
  logic [2:0] id_pcsrc, ex_pcsrc;
  logic       ex_memrd, mem_memrd, ex_alu_zero, mdu_start, undefine, irq_valid;

  logic a_pc_hold, a_if_hold, a_if_flush, a_id_flush, a_mdu_busy, a_irq_ack;
  logic b_pc_hold, b_if_hold, b_if_flush, b_id_flush, b_mdu_busy, b_irq_ack;
`ifdef HAZARD_PERF_EN
  logic [31:0] a_perf_stall, a_perf_flush, b_perf_stall, b_perf_flush;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_unit_mc #(.LOAD_LAT(1), .MDU_LAT(32)) dut_a (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reads_hilo(id_reads_hilo),
    .id_is_mdu(id_is_mdu), .id_pcsrc(id_pcsrc), .ex_memrd(ex_memrd), .ex_rt(ex_rt),
    .mem_memrd(mem_memrd), .mem_rt(mem_rt), .ex_pcsrc(ex_pcsrc), .ex_alu_zero(ex_alu_zero),
    .mdu_start(mdu_start), .undefine(undefine), .irq_valid(irq_valid),
    .pc_hold(a_pc_hold), .if_hold(a_if_hold), .if_flush(a_if_flush), .id_flush(a_id_flush),
    .mdu_busy(a_mdu_busy),
`ifdef HAZARD_PERF_EN
    .perf_stall_cnt(a_perf_stall), .perf_flush_cnt(a_perf_flush),
`endif
    .irq_ack(a_irq_ack));

  hazard_unit_mc #(.LOAD_LAT(2), .MDU_LAT(4)) dut_b (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reads_hilo(id_reads_hilo),
    .id_is_mdu(id_is_mdu), .id_pcsrc(id_pcsrc), .ex_memrd(ex_memrd), .ex_rt(ex_rt),
    .mem_memrd(mem_memrd), .mem_rt(mem_rt), .ex_pcsrc(ex_pcsrc), .ex_alu_zero(ex_alu_zero),
    .mdu_start(mdu_start), .undefine(undefine), .irq_valid(irq_valid),
    .pc_hold(b_pc_hold), .if_hold(b_if_hold), .if_flush(b_if_flush), .id_flush(b_id_flush),
    .mdu_busy(b_mdu_busy),
`ifdef HAZARD_PERF_EN
    .perf_stall_cnt(b_perf_stall), .perf_flush_cnt(b_perf_flush),
`endif
    .irq_ack(b_irq_ack));

  // Reference model state: per instance, pending irq and timestamp of the latest mdu_start.
  int  lat_load [2] = '{1, 2};
  int  lat_mdu  [2] = '{32, 4};
  bit  m_pend   [2];
  bit  m_started[2];
  int  m_start_cyc[2];
  int  m_perf_st[2];
  int  m_perf_fl[2];
  int  cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit dep(input logic use_x, input logic [4:0] src, input logic [4:0] dst);
    return use_x && (src != 5'd0) && (src == dst);
  endfunction

  // Expected {pc_hold, if_hold, if_flush, id_flush, mdu_busy, irq_ack} for instance k this cycle.
  function automatic bit [5:0] model_out(input int k);
    bit ld, busy, stall, redirect, jump, req;
    if (reset) return 6'b0;
    ld = ex_memrd && (dep(id_uses_rs, id_rs, ex_rt) || dep(id_uses_rt, id_rt, ex_rt));
    if (lat_load[k] == 2)
      ld = ld || (mem_memrd && (dep(id_uses_rs, id_rs, mem_rt) || dep(id_uses_rt, id_rt, mem_rt)));
    busy = m_started[k] && (lat_mdu[k] != 0) &&
           (cyc > m_start_cyc[k]) && (cyc <= m_start_cyc[k] + lat_mdu[k]);
    stall    = ld || (busy && (id_reads_hilo || id_is_mdu));
    redirect = ((ex_pcsrc == 3'd1) && ex_alu_zero) || undefine;
    jump     = (id_pcsrc == 3'd2) || (id_pcsrc == 3'd3);
    req      = m_pend[k] || irq_valid;
    if (stall)              return {1'b1, 1'b1, 1'b0, 1'b1, busy, 1'b0};
    else if (redirect)      return {1'b0, 1'b0, 1'b1, 1'b1, busy, 1'b0};
    else if (jump || req)   return {1'b0, 1'b0, 1'b1, 1'b0, busy, req};
    else                    return {1'b0, 1'b0, 1'b0, 1'b0, busy, 1'b0};
  endfunction

  // Advance the model across one clock edge given this cycle's inputs and expected outputs.
  task automatic model_update(input int k, input bit [5:0] o);
    if (reset) begin
      m_pend[k] = 1'b0;
      m_started[k] = 1'b0;
      m_perf_st[k] = 0;
      m_perf_fl[k] = 0;
    end else begin
      m_pend[k] = o[0] ? irq_valid : (m_pend[k] || irq_valid);
      if (mdu_start) begin
        m_started[k] = 1'b1;
        m_start_cyc[k] = cyc;
      end
      m_perf_st[k] += int'(o[5]);
      m_perf_fl[k] += int'(o[3]);
    end
  endtask

  // Inputs already driven after a negedge: check both instances, then cross the rising edge.
  task automatic step(input string tag);
    bit [5:0] ea, eb;
    #1;
    ea = model_out(0);
    eb = model_out(1);
    check_eq({tag, "_l1"}, 32'({a_pc_hold, a_if_hold, a_if_flush, a_id_flush, a_mdu_busy, a_irq_ack}), 32'(ea));
    check_eq({tag, "_l2"}, 32'({b_pc_hold, b_if_hold, b_if_flush, b_id_flush, b_mdu_busy, b_irq_ack}), 32'(eb));
`ifdef HAZARD_PERF_EN
    check_eq({tag, "_pst"}, a_perf_stall, 32'(m_perf_st[0]));
    check_eq({tag, "_pfl"}, a_perf_flush, 32'(m_perf_fl[0]));
`endif
    @(posedge clk);
    model_update(0, ea);
    model_update(1, eb);
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    reset = 1'b0; id_rs = '0; id_rt = '0; ex_rt = '0; mem_rt = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_reads_hilo = 1'b0; id_is_mdu = 1'b0;
    id_pcsrc = '0; ex_pcsrc = '0; ex_memrd = 1'b0; mem_memrd = 1'b0;
    ex_alu_zero = 1'b0; mdu_start = 1'b0; undefine = 1'b0; irq_valid = 1'b0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    step("reset0");
    step("reset1");
    reset = 1'b0;
    step("idle");

    // Load-use in EX, then the same with $zero as destination.
    ex_memrd = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    step("load_use");
    ex_rt = 5'd0; id_rs = 5'd0;
    step("zero_reg");
    clear_inputs();

    // Load in MEM: only the LOAD_LAT=2 instance stalls.
    mem_memrd = 1'b1; mem_rt = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1;
    step("mem_load");
    clear_inputs();

    // MDU interlock with a restart two cycles after the first start.
    mdu_start = 1'b1;
    step("mdu_t0");
    mdu_start = 1'b0; id_reads_hilo = 1'b1;
    step("mdu_t1");
    mdu_start = 1'b1;
    step("mdu_t2");
    mdu_start = 1'b0;
    for (int i = 3; i <= 8; i++) step($sformatf("mdu_t%0d", i));
    clear_inputs();

    // Interrupt pulse during a load stall is held, then serviced once unstalled.
    reset = 1'b1; step("rst_irq"); reset = 1'b0;
    ex_memrd = 1'b1; ex_rt = 5'd4; id_rs = 5'd4; id_uses_rs = 1'b1; irq_valid = 1'b1;
    step("irq_stall0");
    irq_valid = 1'b0;
    step("irq_stall1");
    clear_inputs();
    step("irq_ack");
    step("irq_after");

    // EX branch taken beats an ID jump.
    ex_pcsrc = 3'd1; ex_alu_zero = 1'b1; id_pcsrc = 3'd2;
    step("br_vs_jump");
    clear_inputs();
    id_pcsrc = 3'd3;
    step("jr");
    clear_inputs();

    // Reset in the middle of a busy window.
    mdu_start = 1'b1; step("busy0");
    mdu_start = 1'b0; step("busy1");
    reset = 1'b1; step("busy_rst");
    reset = 1'b0; step("busy_after");

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      reset         = ($urandom_range(0, 99) < 2);
      id_rs         = 5'($urandom_range(0, 3));
      id_rt         = 5'($urandom_range(0, 3));
      ex_rt         = 5'($urandom_range(0, 3));
      mem_rt        = 5'($urandom_range(0, 3));
      id_uses_rs    = 1'($urandom);
      id_uses_rt    = 1'($urandom);
      id_reads_hilo = ($urandom_range(0, 99) < 20);
      id_is_mdu     = ($urandom_range(0, 99) < 10);
      id_pcsrc      = 3'($urandom_range(0, 4));
      ex_pcsrc      = 3'($urandom_range(0, 3));
      ex_memrd      = ($urandom_range(0, 99) < 30);
      mem_memrd     = ($urandom_range(0, 99) < 30);
      ex_alu_zero   = 1'($urandom);
      mdu_start     = ($urandom_range(0, 99) < 5);
      undefine      = ($urandom_range(0, 99) < 5);
      irq_valid     = ($urandom_range(0, 99) < 15);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
